uart_receiver: RTL and testbench

Serial-to-parallel UART receive path, the counterpart of the transmit mux/PISO chain. Frame format is start bit (0), DATA_BITS data bits LSB first, optional parity bit, then one stop bit (1).
- Synchronises rx_i and detects the start bit.
- Samples each bit at mid-bit using a per-bit cycle counter.
- Checks parity and stop bit.
- Presents the received byte with valid/ack handshake and error flags to the downstream FIFO/controller.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_receiver_if.sv | 28 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_receiver.sv | 156 +++++++++++++++
 tb/tb_uart_receiver.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, line levels, error flag bundle.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Error flags attached to a delivered word.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic overrun_err;
  } rx_flags_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
//   rx_data     : received word, valid while rx_valid = 1
//   rx_valid    : word available, held until acknowledged
//   rx_ack      : consumer accepts the word this cycle
//   parity_err / frame_err / overrun_err : flags of the held word
// master = receiver, slave = consumer.
interface uart_receiver_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ack
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
//   clk, nrst : clock, async active-low reset
//   d_i       : asynchronous input
//   q_o       : synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start detect, mid-bit sampling, parity/stop check and
// a held output word with valid/ack handshake and error flags.
//   clk, nrst : clock, async active-low reset
//   rx_i      : serial line (asynchronous, idles high)
//   busy_o    : 1 whenever the FSM is not idle
//   rx_if     : word handshake (master side)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            rx_i,
  output logic            busy_o,
  uart_receiver_if.master rx_if
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pend_perr_q, pend_perr_d;
  logic                 load_c;
  logic                 stop_bad_c;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  rx_flags_t            flags_q, flags_d;
  logic                 busy_d;

  uart_rx_sync u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (rx_i),
    .q_o  (rx_s)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pend_perr_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      flags_q     <= '0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pend_perr_q <= pend_perr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      flags_q     <= flags_d;
      busy_o      <= busy_d;
    end
  end

  // Next state, bit timing and sampling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pend_perr_d = pend_perr_q;
    load_c      = 1'b0;
    stop_bad_c  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s == UART_START_LVL) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (rx_s == UART_IDLE_LVL) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d     = '0;
          // Shift right with new bit at MSB: LSB-first data ends up aligned.
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) state_d = PARITY_EN ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (cnt_q == FULL_TC) begin
          cnt_d       = '0;
          pend_perr_d = ^{shift_q, rx_s, PARITY_ODD};
          state_d     = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (cnt_q == FULL_TC) begin
          cnt_d      = '0;
          state_d    = RX_IDLE;
          load_c     = 1'b1;
          stop_bad_c = (rx_s == UART_START_LVL);
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output word, flags and handshake.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    flags_d = flags_q;
    busy_d  = (state_d != RX_IDLE);
    if (load_c) begin
      data_d              = shift_q;
      valid_d             = 1'b1;
      flags_d.parity_err  = PARITY_EN & pend_perr_q;
      flags_d.frame_err   = stop_bad_c;
      flags_d.overrun_err = valid_q & ~rx_if.rx_ack;
    end else if (valid_q && rx_if.rx_ack) begin
      valid_d = 1'b0;
      flags_d = '0;
    end
  end

  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.parity_err  = flags_q.parity_err;
  assign rx_if.frame_err   = flags_q.frame_err;
  assign rx_if.overrun_err = flags_q.overrun_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at default parameters.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic rx = UART_IDLE_LVL;
  logic busy;

  uart_receiver_if #(.DATA_BITS(8)) rx_if ();

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .PARITY_EN    (1'b1),
    .PARITY_ODD   (1'b0)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .rx_i   (rx),
    .busy_o (busy),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   loads = 0;
  int   load_cyc = 0;
  int   frame_t0 = 0;
  int   exp_loads = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic o);
    exp_t e;
    e.data = d; e.perr = p; e.ferr = f; e.ovr = o;
    sb.push_back(e);
    exp_loads++;
  endtask

  // Drive one frame; optionally pulse ack over the edge ack_at+1 after start.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int ack_at);
    logic [10:0] bits;
    int c;
    bits = {stop, par, d, UART_START_LVL};
    c = 0;
    @(negedge clk);
    frame_t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (CPB) begin
        @(negedge clk);
        c++;
        if (c == ack_at) rx_if.rx_ack = 1'b1;
        else if (c == ack_at + 1) rx_if.rx_ack = 1'b0;
      end
    end
    rx = UART_IDLE_LVL;
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
    check_eq({tag, "_valid_clr"}, 32'(rx_if.rx_valid), 32'd0);
    check_eq({tag, "_flags_clr"},
             32'({rx_if.parity_err, rx_if.frame_err, rx_if.overrun_err}), 32'd0);
  endtask

  // Monitor: a load is a valid rise or a change of the held word/flags.
  initial begin : monitor
    logic       pv;
    logic [7:0] pd;
    logic [2:0] pf;
    logic [2:0] fl;
    exp_t       e;
    pv = 1'b0; pd = '0; pf = '0;
    forever begin
      @(posedge clk);
      #1;
      fl = {rx_if.parity_err, rx_if.frame_err, rx_if.overrun_err};
      if (rx_if.rx_valid && (!pv || rx_if.rx_data != pd || fl != pf)) begin
        loads++;
        load_cyc = cyc;
        check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("rx_data", 32'(rx_if.rx_data), 32'(e.data));
          check_eq("parity_err", 32'(rx_if.parity_err), 32'(e.perr));
          check_eq("frame_err", 32'(rx_if.frame_err), 32'(e.ferr));
          check_eq("overrun_err", 32'(rx_if.overrun_err), 32'(e.ovr));
        end
      end
      pv = rx_if.rx_valid;
      pd = rx_if.rx_data;
      pf = fl;
    end
  end

  initial begin : main
    int lat;
    int loads_snap;
    rx_if.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check_eq("rst_data", 32'(rx_if.rx_data), 32'd0);
    check_eq("rst_flags", 32'({rx_if.parity_err, rx_if.frame_err, rx_if.overrun_err}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame with latency check.
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, -5);
    lat = load_cyc - frame_t0;
    check_eq("latency_172pm1", 32'(lat >= 171 && lat <= 173), 32'd1);
    check_eq("a5_valid", 32'(rx_if.rx_valid), 32'd1);
    do_ack("a5");

    // Wrong parity bit for even parity.
    push_exp(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, -5);
    do_ack("3c");

    // Bad stop bit, then a clean frame after the line returns high.
    push_exp(8'h81, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, -5);
    do_ack("81");
    repeat (2 * CPB) @(negedge clk);
    check_eq("after_bad_stop_busy", 32'(busy), 32'd0);
    push_exp(8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, -5);
    do_ack("55");

    // Short low glitch rejected by START.
    loads_snap = loads;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check_eq("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (2 * CPB) @(negedge clk);
    check_eq("glitch_busy_lo", 32'(busy), 32'd0);
    check_eq("glitch_no_valid", 32'(rx_if.rx_valid), 32'd0);
    check_eq("glitch_no_load", 32'(loads), 32'(loads_snap));

    // Back-to-back without ack: overrun.
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    push_exp(8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b1, -5);
    send_frame(8'h22, 1'b0, 1'b1, -5);
    do_ack("ovr");

    // Ack coincident with the second load: no overrun, valid stays high.
    push_exp(8'h11, 1'b0, 1'b0, 1'b0);
    push_exp(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, -5);
    send_frame(8'h22, 1'b0, 1'b1, 170);
    check_eq("ackload_valid", 32'(rx_if.rx_valid), 32'd1);
    do_ack("ackload");

    // Reset in the middle of DATA for 0xF0 (low nibble first = zeros).
    loads_snap = loads;
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    check_eq("mid_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_valid", 32'(rx_if.rx_valid), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_eq("rst_mid_no_load", 32'(loads), 32'(loads_snap));
    push_exp(8'h0F, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1, -5);
    do_ack("0f");

    repeat (4) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("load_count", 32'(loads), 32'(exp_loads));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
